// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU data path
// and an external requester (loader / debug port).
//
// The CPU normally owns the port. A pending external request takes the port
// when the CPU is idle, or after it has been blocked by CPU traffic for
// STARVE_MAX consecutive cycles. While external traffic owns the port, a CPU
// access is stalled. The external side keeps the port for at most BURST_MAX
// consecutive granted cycles, then hands it back to the CPU.
//
// Optional feature: define DMEM_ARB_STATS_EN to build the saturating grant and
// stall statistics counters. Without it both statistics outputs are tied to 0.

module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,   // legal 1..15
    parameter int unsigned BURST_MAX  = 8    // legal 1..255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    // CPU data-memory port
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_stall_o,

    // external requester port
    input  logic        ext_req_i,
    input  logic        ext_we_i,
    input  logic [7:0]  ext_addr_i,
    input  logic [7:0]  ext_wdata_i,
    output logic        ext_gnt_o,
    output logic [7:0]  ext_rdata_o,
    output logic        ext_rvalid_o,

    // single-port data memory (combinational read)
    output logic [7:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_we_o,
    input  logic [7:0]  mem_rdata_i,

    // statistics
    output logic [15:0] stat_ext_cnt_o,
    output logic [15:0] stat_stall_cnt_o
);

    // Last legal counter values; reaching them triggers a hand-over.
    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);
    localparam logic [7:0] BURST_LAST  = 8'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        ST_CPU = 1'b0,
        ST_EXT = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  starve_q;
    logic [7:0]  burst_q;

    logic        ext_gnt_s;
    logic        cpu_stall_s;
    logic        mem_we_s;
    logic [7:0]  mem_addr_s;
    logic [7:0]  mem_wdata_s;

    logic [7:0]  ext_rdata_q;
    logic        ext_rvalid_q;

    // Port ownership FSM with its starvation and burst-length counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_CPU;
            starve_q <= 4'd0;
            burst_q  <= 8'd0;
        end else begin
            case (state_q)
                ST_CPU: begin
                    if (!ext_req_i) begin
                        // nobody waiting: starvation history is forgotten
                        starve_q <= 4'd0;
                    end else if (!cpu_req_i || (starve_q == STARVE_LAST)) begin
                        // CPU idle, or ext has waited long enough
                        state_q  <= ST_EXT;
                        starve_q <= 4'd0;
                        burst_q  <= 8'd0;
                    end else begin
                        // ext blocked by CPU traffic this cycle
                        starve_q <= starve_q + 4'd1;
                    end
                end
                ST_EXT: begin
                    if (!ext_req_i) begin
                        // requester went away: no access, port back to CPU
                        state_q  <= ST_CPU;
                        starve_q <= 4'd0;
                    end else if (burst_q == BURST_LAST) begin
                        // Burst limit hit on a granted cycle. The CPU gets the
                        // port for one cycle; the requester is still waiting,
                        // so it is treated as already starved and gets back in
                        // right after that single CPU cycle.
                        state_q  <= ST_CPU;
                        starve_q <= STARVE_LAST;
                    end else begin
                        burst_q  <= burst_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= ST_CPU;
                    starve_q <= 4'd0;
                    burst_q  <= 8'd0;
                end
            endcase
        end
    end

    // Memory port steering, grant and stall; all forced quiet while reset is low.
    always_comb begin
        mem_addr_s  = cpu_addr_i;
        mem_wdata_s = cpu_wdata_i;
        mem_we_s    = 1'b0;
        ext_gnt_s   = 1'b0;
        cpu_stall_s = 1'b0;
        if (state_q == ST_EXT) begin
            mem_addr_s  = ext_addr_i;
            mem_wdata_s = ext_wdata_i;
            // a stalled CPU write never reaches memory here; the held PC
            // re-presents it once the CPU owns the port again
            mem_we_s    = rst_n_i & ext_req_i & ext_we_i;
            ext_gnt_s   = rst_n_i & ext_req_i;
            cpu_stall_s = rst_n_i & cpu_req_i;
        end else begin
            mem_addr_s  = cpu_addr_i;
            mem_wdata_s = cpu_wdata_i;
            mem_we_s    = rst_n_i & cpu_req_i & cpu_we_i;
            ext_gnt_s   = 1'b0;
            cpu_stall_s = 1'b0;
        end
    end

    // Capture external read data one cycle after a granted read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ext_rdata_q  <= 8'h00;
            ext_rvalid_q <= 1'b0;
        end else if (ext_gnt_s && !ext_we_i) begin
            ext_rdata_q  <= mem_rdata_i;
            ext_rvalid_q <= 1'b1;
        end else begin
            // data holds its last value; valid only pulses for one cycle
            ext_rvalid_q <= 1'b0;
        end
    end

    assign mem_addr_o   = mem_addr_s;
    assign mem_wdata_o  = mem_wdata_s;
    assign mem_we_o     = mem_we_s;
    assign ext_gnt_o    = ext_gnt_s;
    assign cpu_stall_o  = cpu_stall_s;
    assign cpu_rdata_o  = mem_rdata_i;
    assign ext_rdata_o  = ext_rdata_q;
    assign ext_rvalid_o = ext_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_ext_q;
    logic [15:0] stat_ext_d;
    logic [15:0] stat_stall_q;
    logic [15:0] stat_stall_d;

    // Saturating increment of the grant and stall counters.
    always_comb begin
        stat_ext_d   = stat_ext_q;
        stat_stall_d = stat_stall_q;
        if (ext_gnt_s && (stat_ext_q != 16'hFFFF)) begin
            stat_ext_d = stat_ext_q + 16'd1;
        end else begin
            stat_ext_d = stat_ext_q;
        end
        if (cpu_stall_s && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_ext_q   <= 16'h0000;
            stat_stall_q <= 16'h0000;
        end else begin
            stat_ext_q   <= stat_ext_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_ext_cnt_o   = stat_ext_q;
    assign stat_stall_cnt_o = stat_stall_q;
`else
    assign stat_ext_cnt_o   = 16'h0000;
    assign stat_stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and read
// returns into queues, a negedge monitor pops and compares them whenever the
// DUT presents ext_gnt or ext_rvalid. Direct checks cover reset, stall and
// CPU read-back values.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [7:0]  ext_addr, ext_wdata, ext_rdata;
    logic        ext_gnt, ext_rvalid;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [15:0] stat_ext, stat_stall;

    logic [7:0]  mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int cyc; logic stall; } gnt_exp_t;
    typedef struct { int cyc; logic [7:0] data; } rd_exp_t;
    gnt_exp_t gnt_q[$];
    rd_exp_t  rd_q[$];
    gnt_exp_t ge;
    rd_exp_t  re;

`ifdef DMEM_ARB_STATS_EN
    localparam logic [15:0] STAT_ONE = 16'd1;
`else
    localparam logic [15:0] STAT_ONE = 16'd0;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .cpu_req_i        (cpu_req),
        .cpu_we_i         (cpu_we),
        .cpu_addr_i       (cpu_addr),
        .cpu_wdata_i      (cpu_wdata),
        .cpu_rdata_o      (cpu_rdata),
        .cpu_stall_o      (cpu_stall),
        .ext_req_i        (ext_req),
        .ext_we_i         (ext_we),
        .ext_addr_i       (ext_addr),
        .ext_wdata_i      (ext_wdata),
        .ext_gnt_o        (ext_gnt),
        .ext_rdata_o      (ext_rdata),
        .ext_rvalid_o     (ext_rvalid),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_we_o         (mem_we),
        .mem_rdata_i      (mem_rdata),
        .stat_ext_cnt_o   (stat_ext),
        .stat_stall_cnt_o (stat_stall)
    );

    // memory model: combinational read, write at the rising edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_gnt(input int c, input logic s);
        gnt_exp_t e;
        e.cyc = c;
        e.stall = s;
        gnt_q.push_back(e);
    endtask

    task automatic push_rd(input int c, input logic [7:0] d);
        rd_exp_t e;
        e.cyc = c;
        e.data = d;
        rd_q.push_back(e);
    endtask

    // one cycle of stimulus, applied just after the rising edge
    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic er, input logic ew, input logic [7:0] ea, input logic [7:0] ed);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: compare every grant and every read return against the scoreboard
    always @(negedge clk) begin
        if (ext_gnt === 1'b1) begin
            if (gnt_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_gnt: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                ge = gnt_q.pop_front();
                chk("gnt_cycle", 32'(cyc), 32'(ge.cyc));
                chk("gnt_stall", 32'(cpu_stall), 32'(ge.stall));
            end
        end
        if (ext_rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                re = rd_q.pop_front();
                chk("rvalid_cycle", 32'(cyc), 32'(re.cyc));
                chk("rdata", 32'(ext_rdata), 32'(re.data));
            end
        end
    end

    initial begin
        int b;
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;
        #2;
        chk("rst_gnt",    32'(ext_gnt),    32'd0);
        chk("rst_stall",  32'(cpu_stall),  32'd0);
        chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
        chk("rst_rdata",  32'(ext_rdata),  32'd0);
        chk("rst_stat_ext",   32'(stat_ext),   32'd0);
        chk("rst_stat_stall", 32'(stat_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle CPU: ext write 0x10 <= 0xA5 granted next cycle, CPU reads it back
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
        b = cyc;
        push_gnt(b + 1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);   // drop in EXT: no access
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("idle_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("idle_readback",  32'(cpu_rdata), 32'hA5);

        // starvation: CPU writes 0x40 every cycle, ext write waits 4 cycles
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 8'h40, 8'(8'h50 + k), (k < 5), 1'b1, 8'h30, 8'h11);
            if (k == 0) begin
                b = cyc;
                push_gnt(b + 4, 1'b1);
            end
        end
        @(negedge clk);
        chk("starve_stall_after_drop", 32'(cpu_stall), 32'd1);
        chk("stat_ext_after_first",    32'(stat_ext),  32'(STAT_ONE));
        chk("stat_stall_after_first",  32'(stat_stall), 32'(STAT_ONE));
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("stalled_write_dropped", 32'(cpu_rdata), 32'h53);
        drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("starved_ext_write", 32'(cpu_rdata), 32'h11);

        // burst limit: grants 4..11, one CPU cycle at 12, grants 13..19
        do_reset();
        for (int k = 0; k < 22; k++) begin
            drive(1'b1, 1'b0, 8'h00, 8'h00, (k < 20), 1'b1, 8'(8'h80 + k), 8'(k));
            if (k == 0) begin
                b = cyc;
                for (int j = 4; j < 20; j++) begin
                    if (j != 12) push_gnt(b + j, 1'b1);
                end
            end
            if (k == 12 || k == 20 || k == 21) begin
                @(negedge clk);
                chk("burst_gap_gnt", 32'(ext_gnt), 32'd0);
                chk("burst_gap_stall", 32'(cpu_stall), (k == 20) ? 32'd1 : 32'd0);
            end
        end

        // read latency: reads of 0x20/0x21, then a write (no rvalid)
        do_reset();
        drive(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 8'h21, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        b = cyc;
        push_gnt(b + 1, 1'b0);
        push_gnt(b + 2, 1'b0);
        push_gnt(b + 3, 1'b0);
        push_rd(b + 2, 8'h3C);
        push_rd(b + 3, 8'h5A);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h22, 8'h99);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rvalid_after_write", 32'(ext_rvalid), 32'd0);
        chk("rdata_hold",         32'(ext_rdata),  32'h5A);

        // reset mid-burst: write to 0x50 must be suppressed
        do_reset();
        drive(1'b1, 1'b1, 8'h50, 8'h0F, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'h01);
        b = cyc;
        push_gnt(b + 1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'h01);
        drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b1, 8'h50, 8'hEE);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt",    32'(ext_gnt),   32'd0);
        chk("midrst_stall",  32'(cpu_stall), 32'd0);
        chk("midrst_mem_we", 32'(mem_we),    32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_stall", 32'(cpu_stall), 32'd0);
        chk("postrst_gnt",   32'(ext_gnt),   32'd0);
        drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("midrst_mem_unchanged", 32'(cpu_rdata), 32'h0F);

        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
        chk("rd_queue_empty",  32'(rd_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive cycles a pending ext request may be blocked by CPU traffic (legal 1..15).
REQ-002 Parameter BURST_MAX, default 8, SHALL set the maximum consecutive ext accesses per grant (legal 1..255).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous and active-low; 0 resets the block.
REQ-005 cpu_req  in  1  CPU data-memory access this cycle, from the control unit.
REQ-006 cpu_we / cpu_addr / cpu_wdata  in  1/8/8  CPU write enable, address and write data.
REQ-007 cpu_rdata  out  8  memory read data to the CPU, combinational.
REQ-008 cpu_stall  out  1  SHALL hold the PC and inhibit register loads while high.
REQ-009 ext_req / ext_we / ext_addr / ext_wdata  in  1/1/8/8  external requester (loader/debug) access.
REQ-010 ext_gnt  out  1  ext access performed this cycle.
REQ-011 ext_rdata / ext_rvalid  out  8/1  registered read data and its one-cycle valid.
REQ-012 mem_addr / mem_wdata / mem_we  out  8/8/1  single-port data memory; mem_rdata  in  8, combinational.
REQ-013 stat_ext_cnt / stat_stall_cnt  out  16/16  statistics (see Configuration).

Function
REQ-014 FSM states SHALL be CPU (CPU owns port) and EXT (ext owns port).
REQ-015 In CPU: mem_* SHALL carry cpu_addr/cpu_wdata; mem_we = cpu_req & cpu_we; cpu_stall = 0; ext_gnt = 0.
REQ-016 In EXT: mem_* SHALL carry ext_*; mem_we = ext_req & ext_we; ext_gnt = ext_req; cpu_stall = cpu_req.
REQ-017 CPU->EXT SHALL occur when ext_req=1 and either cpu_req=0 or starve_cnt = STARVE_MAX-1.
REQ-018 starve_cnt (4 bit) SHALL increment each CPU-state cycle with ext_req=1 and cpu_req=1, clear on entering EXT or when ext_req=0, and never exceed STARVE_MAX-1.
REQ-019 EXT->CPU SHALL occur when ext_req=0, or when burst_cnt reaches BURST_MAX-1 on a granted cycle; burst_cnt (8 bit) clears on entering EXT.
REQ-020 After a BURST_MAX-terminated burst with cpu_req=1, the block SHALL stay in CPU at least one cycle before re-entering EXT.
REQ-021 Grant latency: ext_req rising with cpu_req=0 in cycle N SHALL give ext_gnt=1 in cycle N+1.
REQ-022 Write on a granted cycle SHALL commit at that cycle's closing edge; read SHALL present ext_rdata with ext_rvalid=1 exactly one cycle after ext_gnt.
REQ-023 ext_rvalid SHALL be 0 for granted writes and non-granted cycles; ext_rdata holds its last value otherwise.
REQ-024 ext_req dropping while in EXT SHALL produce no access that cycle and return to CPU next cycle.
REQ-025 cpu_rdata SHALL equal mem_rdata in all states; it is meaningful only when cpu_stall=0.
REQ-026 A stalled CPU write SHALL never reach memory; it is re-presented by the held PC.

Reset
REQ-027 On reset=0: state CPU, starve_cnt=0, burst_cnt=0, ext_rdata=0, ext_rvalid=0, statistics=0; ext_gnt=0, cpu_stall=0 immediately.
REQ-028 Reset asserted mid-burst SHALL abort the burst; no write SHALL occur on the cycle reset is low.

Configuration
REQ-029 Macro DMEM_ARB_STATS_EN defined: stat_ext_cnt SHALL count granted ext cycles, stat_stall_cnt cycles with cpu_stall=1; both saturate at 16'hFFFF.
REQ-030 DMEM_ARB_STATS_EN undefined: both stat outputs SHALL be constant 0 with no counter logic; all other behaviour identical.

Verification
REQ-031 Idle CPU: ext_req=1, ext_we=1, addr 8'h10, data 8'hA5 at cycle 0 -> ext_gnt=1 cycle 1; later CPU read of 8'h10 returns 8'hA5.
REQ-032 Starvation: cpu_req=1 continuously, ext_req=1 from cycle 0 -> first ext_gnt at cycle 4 (STARVE_MAX=4), cpu_stall=1 that cycle.
REQ-033 Burst limit: ext_req held 20 cycles, cpu_req=1 -> grants in runs of 8, each followed by exactly one cpu_stall=0 cycle.
REQ-034 Read latency: ext read of addr 8'h20 holding 8'h3C -> ext_rvalid=1, ext_rdata=8'h3C one cycle after ext_gnt.
REQ-035 Reset mid-burst: reset=0 during EXT write -> memory word unchanged, state CPU, ext_gnt=0, cpu_stall=0 immediately.
REQ-036 With DMEM_ARB_STATS_EN: after REQ-032 scenario's first grant, stat_ext_cnt=1, stat_stall_cnt=1; without it both read 0.
